// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one registered adder among four requesters
module n_bit_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);
    // registered modulo-2^N sum, loaded only when enabled
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sum <= '0;
        else if (en) sum <= a + b;
endmodule

module adder_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] a_in,
    input  logic [4*N-1:0] b_in,
    output logic [3:0]     gnt,
    output logic           busy,
    output logic [N-1:0]   sum_out,
    output logic           sum_valid,
    output logic [1:0]     sum_id
);
    typedef enum logic {IDLE, ADD} state_t;
    state_t state, state_nx;
    logic [1:0] ptr, win, idx, id_q;
    logic found, add_en;
    logic [N-1:0] op_a, op_b;

    assign busy = state == ADD;

    // round-robin winner search from ptr upward plus next-state decode
    always_comb begin
        win = ptr;
        idx = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
        add_en = state == ADD;
        state_nx = state == IDLE ? (found ? ADD : IDLE) : IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // operand latch, grant, pointer rotation and result tagging
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            gnt       <= '0;
            id_q      <= '0;
            sum_valid <= 1'b0;
            sum_id    <= '0;
        end else begin
            gnt       <= '0;
            sum_valid <= 1'b0;
            if (state == IDLE && found) begin
                op_a <= a_in[win*N +: N];
                op_b <= b_in[win*N +: N];
                gnt  <= 4'b0001 << win;
                id_q <= win;
                ptr  <= win + 2'd1;
            end
            if (state == ADD) begin
                sum_valid <= 1'b1;
                sum_id    <= id_q;
            end
        end

    n_bit_adder #(.N(N)) u_add (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (add_en),
        .a     (op_a),
        .b     (op_b),
        .sum   (sum_out)
    );
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter
module tb_adder_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req16;
    logic [31:0] a_in, b_in;
    logic [63:0] a16, b16;
    logic [3:0]  gnt, gnt16;
    logic        busy, busy16, sum_valid, sum_valid16;
    logic [7:0]  sum_out;
    logic [15:0] sum16;
    logic [1:0]  sum_id, sum_id16;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .sum_out(sum_out), .sum_valid(sum_valid), .sum_id(sum_id)
    );

    adder_arbiter #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req16), .a_in(a16), .b_in(b16),
        .gnt(gnt16), .busy(busy16), .sum_out(sum16), .sum_valid(sum_valid16), .sum_id(sum_id16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
        a_in[k*8 +: 8] = a;
        b_in[k*8 +: 8] = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = '0; req16 = '0; a_in = '0; b_in = '0; a16 = '0; b16 = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(sum_out), 0);
        chk("rst_valid", 32'(sum_valid), 0);
        chk("rst_id", 32'(sum_id), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 0);

        set_op(2, 8'h12, 8'h34); req = 4'b0100;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'b0100);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_nvalid", 32'(sum_valid), 0);
        req = '0;
        @(negedge clk);
        chk("t1_valid", 32'(sum_valid), 1);
        chk("t1_sum", 32'(sum_out), 32'h46);
        chk("t1_id", 32'(sum_id), 2);
        chk("t1_gnt0", 32'(gnt), 0);
        chk("t1_busy0", 32'(busy), 0);
        @(negedge clk);
        chk("t1_pulse", 32'(sum_valid), 0);
        chk("t1_hold", 32'(sum_out), 32'h46);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) set_op(k, 8'(8'h10 * k), 8'(k + 1));
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
            chk("rr_nvalid", 32'(sum_valid), 0);
            @(negedge clk);
            chk("rr_valid", 32'(sum_valid), 1);
            chk("rr_id", 32'(sum_id), 32'(i % 4));
            chk("rr_sum", 32'(sum_out), 32'(8'(8'h11 * (i % 4) + 1)));
            chk("rr_gnt0", 32'(gnt), 0);
        end
        req = '0;

        set_op(1, 8'hFF, 8'h01); req = 4'b0010;
        @(negedge clk);
        chk("wrap_gnt", 32'(gnt), 32'b0010);
        req = '0;
        @(negedge clk);
        chk("wrap_valid", 32'(sum_valid), 1);
        chk("wrap_sum", 32'(sum_out), 0);
        chk("wrap_id", 32'(sum_id), 1);

        set_op(0, 8'h20, 8'h05); set_op(3, 8'h40, 8'h03);
        req = 4'b0001;
        @(negedge clk);
        chk("ar_gnt", 32'(gnt), 32'b0001);
        chk("ar_busy", 32'(busy), 1);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt0", 32'(gnt), 0);
        chk("ar_busy0", 32'(busy), 0);
        chk("ar_sum0", 32'(sum_out), 0);
        chk("ar_valid0", 32'(sum_valid), 0);
        @(negedge clk);
        chk("ar_novalid", 32'(sum_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_novalid2", 32'(sum_valid), 0);
        chk("ar_idle", 32'(busy), 0);
        req = 4'b1001;
        @(negedge clk);
        chk("ar_ptr0", 32'(gnt), 32'b0001);
        req = '0;
        @(negedge clk);
        chk("ar_sum", 32'(sum_out), 32'h25);
        chk("ar_id", 32'(sum_id), 0);

        req = 4'b1000;
        @(negedge clk);
        chk("rot_g3", 32'(gnt), 32'b1000);
        req = 4'b1001;
        @(negedge clk);
        chk("rot_id3", 32'(sum_id), 3);
        chk("rot_sum3", 32'(sum_out), 32'h43);
        @(negedge clk);
        chk("rot_g0", 32'(gnt), 32'b0001);
        @(negedge clk);
        chk("rot_id0", 32'(sum_id), 0);
        @(negedge clk);
        chk("rot_g3b", 32'(gnt), 32'b1000);
        req = '0;
        @(negedge clk);
        chk("rot_id3b", 32'(sum_id), 3);

        a16[15:0] = 16'h8000; b16[15:0] = 16'h7FFF; req16 = 4'b0001;
        @(negedge clk);
        chk("w16_gnt", 32'(gnt16), 32'b0001);
        req16 = '0;
        @(negedge clk);
        chk("w16_valid", 32'(sum_valid16), 1);
        chk("w16_sum", 32'(sum16), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one registered `n_bit_adder` instance among four requesters. It grants one requester at a time and latches that requester's operands. One cycle later it returns the N-bit sum with a valid pulse and the winning requester's ID. It sits between the processor's functional units (PC incrementer, address generator, ALU, branch-offset unit) and the single shared adder, so only one adder is needed.

## Interface
Parameters:
- `N`, 8, operand and sum width; passed through to the internal `n_bit_adder`.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `req`  input  4  request lines; `req[k]` high means requester k wants an addition.
- `a_in`  input  4*N  operand A buses; requester k drives `a_in[k*N +: N]`.
- `b_in`  input  4*N  operand B buses; requester k drives `b_in[k*N +: N]`.
- `gnt`  output  4  one-hot grant, registered; high for exactly one cycle per accepted request.
- `busy`  output  1  high while an addition is in flight (state ADD).
- `sum_out`  output  N  registered sum; holds its last value until the next result.
- `sum_valid`  output  1  one-cycle pulse when `sum_out` carries a new result.
- `sum_id`  output  2  index of the requester that owns the current `sum_out`.

## Operation
- Two-state FSM:
  - IDLE: arbitrate among `req`.
  - ADD: the latched operands are presented to the adder.
- IDLE with `req` == 0: stay in IDLE; all outputs hold their values, except `gnt` = 0 and `sum_valid` = 0.
- IDLE with any `req` set, winner k selected:
  - k is the first set bit found searching upward from `ptr` (2-bit round-robin pointer), wrapping 3→0.
  - On the clock edge: `op_a` <= `a_in` slice k, `op_b` <= `b_in` slice k, `gnt` <= one-hot k, `id_q` <= k, `ptr` <= k+1 mod 4, state <= ADD.
- ADD:
  - `req` is ignored, so no arbitration happens.
  - On the clock edge: `sum_out` <= `op_a` + `op_b`, `sum_valid` <= 1, `sum_id` <= `id_q`, `gnt` <= 0, state <= IDLE.
- Arithmetic: the sum is taken modulo 2^N. There is no carry-in, no carry-out and no overflow flag, which matches the adder.
- Requester handshake:
  - Hold `req[k]` and the operands stable until `gnt[k]` is seen high.
  - Deassert `req[k]` during the `gnt[k]` cycle.
  - If `req[k]` is still high in the following IDLE cycle, it is a new request.
- Pointer fairness: a continuously requesting unit waits at most 3 other grants before it is served.
- Reset (`rst_n` low, at any time, including mid-ADD):
  - State = IDLE, `ptr` = 0, so `req[0]` has highest priority.
  - `gnt` = 0, `busy` = 0, `sum_out` = 0, `sum_valid` = 0, `sum_id` = 0, `op_a` = 0, `op_b` = 0.
  - An in-flight operation is discarded and produces no `sum_valid`.
  - Operation resumes at the first rising edge after `rst_n` goes high.

## Timing
- Edge E0, IDLE sampling `req`:
  - After E0: `gnt`[k] = 1, `busy` = 1.
  - After E1: `sum_valid` = 1, `sum_out` valid, `gnt` = 0, `busy` = 0.
- Latency from request sampled to result: 2 cycles.
- Throughput: one addition per 2 cycles.
- The earliest next grant comes after E2, in the same edge that clears `sum_valid`. `gnt` and `sum_valid` are never both high.
- `sum_valid` is always a single-cycle pulse. `sum_out` and `sum_id` remain stable until the next result.
- All outputs are registered. Inputs need to be valid only at the IDLE sampling edge.

## Test plan
- Reset, then `req`=4'b0100 with slice 2: a=8'h12, b=8'h34 → `gnt`=4'b0100 one cycle later. The next cycle gives `sum_valid`=1, `sum_out`=8'h46, `sum_id`=2.
- All four requesters held high continuously after reset → grant order 0,1,2,3,0 with one grant every 2 cycles. Each `sum_id` matches the preceding grant.
- Requester 1 with a=8'hFF, b=8'h01 → `sum_out`=8'h00, `sum_valid`=1 (wrap, no overflow flag).
- Request accepted, then `rst_n` pulsed low during the ADD cycle → `gnt`, `busy` and `sum_out` all go to 0 immediately, no `sum_valid` ever appears, and `ptr` restarts so `req[0]` wins next.
- `req[3]` held high across its own grant while `req[0]` rises later → requester 3 is served, then requester 0 is served before requester 3 again (rotation past the just-served unit).
- N=16, requester 0 with a=16'h8000, b=16'h7FFF → `sum_out`=16'hFFFF.
